// File: rtl/ascon_pkg.sv
// Shared types and constants for the iterative Ascon-128 encrypt path.
package ascon_pkg;

  // Index [0] holds x0 and index [4] holds x4.
  typedef logic [4:0][63:0] ascon_state_t;

  localparam logic [63:0] ASCON_IV      = 64'h80400c0600000000;
  localparam logic [63:0] ASCON_PAD     = 64'h8000000000000000;
  localparam logic [3:0]  RND_P12_FIRST = 4'd0;
  localparam logic [3:0]  RND_P6_FIRST  = 4'd6;
  localparam logic [3:0]  RND_LAST      = 4'd11;

  typedef enum logic [2:0] {
    PH_LOAD,
    PH_INIT,
    PH_AD1,
    PH_AD2,
    PH_PT,
    PH_FINAL
  } phase_e;

  function automatic logic [7:0] ascon_rc(input logic [3:0] i);
    return {~i, i};
  endfunction

endpackage

// File: rtl/ascon_round.sv
// One Ascon permutation round (constant add, bitsliced S-box, linear layer).
module ascon_round
  import ascon_pkg::*;
(
  input  ascon_state_t s_in,
  input  logic [3:0]   rnd_i,
  output ascon_state_t s_out
);

  function automatic logic [63:0] ror(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  logic [63:0] a0, a1, a2, a3, a4;
  logic [63:0] b0, b1, b2, b3, b4;
  logic [63:0] c0, c1, c2, c3, c4;

  assign a0 = s_in[0] ^ s_in[4];
  assign a1 = s_in[1];
  assign a2 = s_in[2] ^ {56'd0, ascon_rc(rnd_i)} ^ s_in[1];
  assign a3 = s_in[3];
  assign a4 = s_in[4] ^ s_in[3];

  assign b0 = a0 ^ (~a1 & a2);
  assign b1 = a1 ^ (~a2 & a3);
  assign b2 = a2 ^ (~a3 & a4);
  assign b3 = a3 ^ (~a4 & a0);
  assign b4 = a4 ^ (~a0 & a1);

  assign c0 = b0 ^ b4;
  assign c1 = b1 ^ b0;
  assign c2 = ~b2;
  assign c3 = b3 ^ b2;
  assign c4 = b4;

  assign s_out[0] = c0 ^ ror(c0, 19) ^ ror(c0, 28);
  assign s_out[1] = c1 ^ ror(c1, 61) ^ ror(c1, 39);
  assign s_out[2] = c2 ^ ror(c2, 1)  ^ ror(c2, 6);
  assign s_out[3] = c3 ^ ror(c3, 10) ^ ror(c3, 17);
  assign s_out[4] = c4 ^ ror(c4, 7)  ^ ror(c4, 41);

endmodule

// File: rtl/ascon_encrypt_top.sv
// Free-running Ascon-128 encrypt core for one AD block and one PT block, one round per clock.
// state | meaning
// LOAD  | capture inputs, build initial state
// INIT  | p12, key folded into x3/x4 on last round
// AD1   | A folded into x0 on first round, p6
// AD2   | pad block, p6, domain separation on last round
// PT    | P folded into x0 (C captured), p6, empty-block pad on last round
// FINAL | key folded into x1/x2, p12, publish C and T
module ascon_encrypt_top
  import ascon_pkg::*;
(
  input  logic         CLK,
  input  logic         RST,
  input  logic [127:0] SK,
  input  logic [127:0] N,
  input  logic [63:0]  A,
  input  logic [63:0]  P,
  output logic [63:0]  C,
  output logic [127:0] T
);

  phase_e       phase_q, phase_d;
  logic [3:0]   rnd_q, rnd_d;
  ascon_state_t s_q, s_d;
  logic [127:0] sk_q, sk_d, n_q, n_d;
  logic [63:0]  a_q, a_d, p_q, p_d;
  logic [63:0]  c_int_q, c_int_d;
  logic [63:0]  c_q, c_d;
  logic [127:0] t_q, t_d;

  ascon_state_t s_pre, s_rnd, s_post;
  logic         first_rnd, last_rnd, restart;
  logic [63:0]  k0, k1;

  assign k0 = sk_q[127:64];
  assign k1 = sk_q[63:0];

  ascon_round u_round (
    .s_in  (s_pre),
    .rnd_i (rnd_q),
    .s_out (s_rnd)
  );

  always_comb begin
    first_rnd = (phase_q == PH_INIT || phase_q == PH_FINAL) ? (rnd_q == RND_P12_FIRST)
                                                             : (rnd_q == RND_P6_FIRST);
    last_rnd  = (rnd_q == RND_LAST);
    restart   = (SK != sk_q) || (N != n_q) || (A != a_q) || (P != p_q);

    // Phase XORs ride on the first or last round so they cost no cycles.
    s_pre = s_q;
    if (first_rnd) begin
      case (phase_q)
        PH_AD1:   s_pre[0] = s_q[0] ^ a_q;
        PH_AD2:   s_pre[0] = s_q[0] ^ ASCON_PAD;
        PH_PT:    s_pre[0] = s_q[0] ^ p_q;
        PH_FINAL: begin
          s_pre[1] = s_q[1] ^ k0;
          s_pre[2] = s_q[2] ^ k1;
        end
        default:  ;
      endcase
    end

    s_post = s_rnd;
    if (last_rnd) begin
      case (phase_q)
        PH_INIT: begin
          s_post[3] = s_rnd[3] ^ k0;
          s_post[4] = s_rnd[4] ^ k1;
        end
        PH_AD2:  s_post[4] = s_rnd[4] ^ 64'd1;
        PH_PT:   s_post[0] = s_rnd[0] ^ ASCON_PAD;
        default: ;
      endcase
    end

    phase_d = phase_q;
    rnd_d   = rnd_q;
    s_d     = s_q;
    sk_d    = sk_q;
    n_d     = n_q;
    a_d     = a_q;
    p_d     = p_q;
    c_int_d = c_int_q;
    c_d     = c_q;
    t_d     = t_q;

    if (phase_q == PH_LOAD) begin
      sk_d    = SK;
      n_d     = N;
      a_d     = A;
      p_d     = P;
      s_d     = {N[63:0], N[127:64], SK[63:0], SK[127:64], ASCON_IV};
      phase_d = PH_INIT;
      rnd_d   = RND_P12_FIRST;
    end else if (restart) begin
      phase_d = PH_LOAD;
      rnd_d   = RND_P12_FIRST;
    end else begin
      s_d = s_post;
      if (phase_q == PH_PT && first_rnd) c_int_d = s_pre[0];
      if (last_rnd) begin
        case (phase_q)
          PH_INIT: begin
            phase_d = PH_AD1;
            rnd_d   = RND_P6_FIRST;
          end
          PH_AD1: begin
            phase_d = PH_AD2;
            rnd_d   = RND_P6_FIRST;
          end
          PH_AD2: begin
            phase_d = PH_PT;
            rnd_d   = RND_P6_FIRST;
          end
          PH_PT: begin
            phase_d = PH_FINAL;
            rnd_d   = RND_P12_FIRST;
          end
          PH_FINAL: begin
            phase_d = PH_LOAD;
            rnd_d   = RND_P12_FIRST;
            c_d     = c_int_q;
            t_d     = {s_rnd[3] ^ k0, s_rnd[4] ^ k1};
          end
          default: begin
            phase_d = PH_LOAD;
            rnd_d   = RND_P12_FIRST;
          end
        endcase
      end else begin
        rnd_d = rnd_q + 4'd1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      phase_q <= PH_LOAD;
      rnd_q   <= '0;
      s_q     <= '0;
      sk_q    <= '0;
      n_q     <= '0;
      a_q     <= '0;
      p_q     <= '0;
      c_int_q <= '0;
      c_q     <= '0;
      t_q     <= '0;
    end else begin
      phase_q <= phase_d;
      rnd_q   <= rnd_d;
      s_q     <= s_d;
      sk_q    <= sk_d;
      n_q     <= n_d;
      a_q     <= a_d;
      p_q     <= p_d;
      c_int_q <= c_int_d;
      c_q     <= c_d;
      t_q     <= t_d;
    end
  end

  assign C = c_q;
  assign T = t_q;

endmodule

// File: tb/tb_ascon_encrypt_top.sv
// Scoreboard bench for ascon_encrypt_top against an S-box-table Ascon-128 model.
module tb_ascon_encrypt_top;

  typedef logic [4:0][63:0] st_t;
  typedef struct {
    logic [191:0] ct;
    int           lo;
    int           hi;
  } exp_t;

  localparam logic [4:0] SBOX [32] = '{
    5'd4,  5'd11, 5'd31, 5'd20, 5'd26, 5'd21, 5'd9,  5'd2,
    5'd27, 5'd5,  5'd8,  5'd18, 5'd29, 5'd3,  5'd6,  5'd28,
    5'd30, 5'd19, 5'd7,  5'd14, 5'd0,  5'd13, 5'd17, 5'd24,
    5'd16, 5'd12, 5'd1,  5'd25, 5'd22, 5'd10, 5'd15, 5'd23};
  localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
  localparam int ROT_B [5] = '{28, 39, 6, 17, 41};
  localparam logic [63:0] IV  = 64'h80400c0600000000;
  localparam logic [63:0] PAD = 64'h8000000000000000;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] SK, N;
  logic [63:0]  A, P;
  logic [63:0]  C;
  logic [127:0] T;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ascon_encrypt_top dut (
    .CLK (clk),
    .RST (rst),
    .SK  (SK),
    .N   (N),
    .A   (A),
    .P   (P),
    .C   (C),
    .T   (T)
  );

  function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic st_t perm(input st_t s, input int r0);
    st_t        x, y;
    logic [4:0] col, o;
    x = s;
    y = '0;
    for (int r = r0; r < 12; r++) begin
      x[2] = x[2] ^ 64'(((15 - r) << 4) | r);
      for (int b = 0; b < 64; b++) begin
        col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
        o   = SBOX[col];
        for (int w = 0; w < 5; w++) y[w][b] = o[4 - w];
      end
      for (int w = 0; w < 5; w++) x[w] = y[w] ^ rotr(y[w], ROT_A[w]) ^ rotr(y[w], ROT_B[w]);
    end
    return x;
  endfunction

  // Returns {C, T} for one 8-byte AD block and one 8-byte PT block.
  function automatic logic [191:0] ascon_ref(input logic [127:0] k, input logic [127:0] nn,
                                             input logic [63:0] a, input logic [63:0] p);
    st_t         x;
    logic [63:0] c;
    x = {nn[63:0], nn[127:64], k[63:0], k[127:64], IV};
    x = perm(x, 0);
    x[3] ^= k[127:64];
    x[4] ^= k[63:0];
    x[0] ^= a;
    x = perm(x, 6);
    x[0] ^= PAD;
    x = perm(x, 6);
    x[4] ^= 64'd1;
    x[0] ^= p;
    c = x[0];
    x = perm(x, 6);
    x[0] ^= PAD;
    x[1] ^= k[127:64];
    x[2] ^= k[63:0];
    x = perm(x, 0);
    return {c, x[3] ^ k[127:64], x[4] ^ k[63:0]};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic apply(input logic [127:0] k, input logic [127:0] nn,
                       input logic [63:0] a, input logic [63:0] p, input bit track);
    exp_t e;
    SK = k;
    N  = nn;
    A  = a;
    P  = p;
    if (track) begin
      e.ct = ascon_ref(k, nn, a, p);
      e.lo = cyc + 43;
      e.hi = cyc + 44;
      sb_q.push_back(e);
    end
  endtask

  task automatic hold_check(input logic [191:0] want);
    checks++;
    if ({C, T} !== want) begin
      errors++;
      $display("FAIL hold_result got %h want %h", {C, T}, want);
    end
  endtask

  task automatic finish_vec(input logic [191:0] want);
    repeat (44) @(posedge clk);
    @(negedge clk);
    hold_check(want);
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input logic [127:0] k, input logic [127:0] nn,
                         input logic [63:0] a, input logic [63:0] p);
    apply(k, nn, a, p, 1'b1);
    finish_vec(ascon_ref(k, nn, a, p));
  endtask

  // Monitor: every output change outside reset must match the next queued result in its window.
  initial begin : monitor
    logic [191:0] last_ct, cur;
    exp_t         e;
    last_ct = '0;
    forever begin
      @(negedge clk);
      cur = {C, T};
      if (rst) begin
        checks++;
        if (cur !== '0) begin
          errors++;
          $display("FAIL reset_zero got %h want 0", cur);
        end
        last_ct = '0;
      end else if (cur !== last_ct) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output got %h want unchanged %h", cur, last_ct);
        end else begin
          e = sb_q.pop_front();
          checks++;
          if (cur !== e.ct) begin
            errors++;
            $display("FAIL result got %h want %h", cur, e.ct);
          end
          checks++;
          if (cyc < e.lo || cyc > e.hi) begin
            errors++;
            $display("FAIL latency got cycle %0d want %0d..%0d", cyc, e.lo, e.hi);
          end
        end
        last_ct = cur;
      end
    end
  end

  initial begin : stim
    logic [127:0] vk, vn;
    logic [63:0]  va, vp, vp2;
    SK  = '0;
    N   = '0;
    A   = '0;
    P   = '0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #10 rst = 1'b0;

    run_vec('0, '0, '0, '0);
    run_vec(128'h000102030405060708090a0b0c0d0e0f, 128'h000102030405060708090a0b0c0d0e0f,
            64'h0001020304050607, 64'h0001020304050607);

    // P changes mid-run: only the restarted run may ever reach the outputs.
    vk = rnd128(); vn = rnd128(); va = rnd64(); vp = rnd64();
    apply(vk, vn, va, vp, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    vp2 = vp ^ (rnd64() | 64'd1);
    apply(vk, vn, va, vp2, 1'b1);
    finish_vec(ascon_ref(vk, vn, va, vp2));

    // Reset lands in FINAL round 5; outputs must clear at once and the rerun must complete.
    vk = rnd128(); vn = rnd128(); va = rnd64(); vp = rnd64();
    apply(vk, vn, va, vp, 1'b0);
    repeat (37) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({C, T} !== '0) begin
      errors++;
      $display("FAIL reset_immediate got %h want 0", {C, T});
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    apply(vk, vn, va, vp, 1'b1);
    finish_vec(ascon_ref(vk, vn, va, vp));

    for (int v = 0; v < 500; v++) begin
      run_vec(rnd128(), rnd128(), rnd64(), rnd64());
    end

    repeat (50) @(posedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL pending_results got %0d want 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ascon_encrypt_top.md
# ascon_encrypt_top

Ascon-128 (v1.2) authenticated-encryption core for a single 64-bit associated-data block and a single 64-bit plaintext block. It produces the 64-bit ciphertext and the 128-bit tag. The core is iterative, computing one permutation round per clock. It is free-running on level inputs with no start/done handshake, and is the top level of the lightweight Ascon encrypt path.

## Interface
- No parameters.
- CLK  in  1  — clock; all state updates on the rising edge.
- RST  in  1  — asynchronous, active-high reset.
- SK  in  128  — key; SK[127:64] is K0, the first 8 key bytes, big-endian.
- N  in  128  — nonce; N[127:64] is N0, N[63:0] is N1.
- A  in  64  — associated data, exactly one full block.
- P  in  64  — plaintext, exactly one full block.
- C  out  64  — ciphertext, registered.
- T  out  128  — tag, registered; T[127:64] is the first tag word.

## Operation
- State is five 64-bit words x0..x4. The round uses bitsliced Ascon operations:
  - pc: x2 ^= {56'b0, rc}.
  - ps: the 5-bit S-box.
  - pl: rotate-rights (19,28), (61,39), (1,6), (10,17), (7,41) for x0..x4.
- Round constants: rc(i) = {~i[3:0], i[3:0]} for i = 0..11, giving 0xf0..0x4b. p12 uses i = 0..11; p6 uses i = 6..11.
- Sequence:
  1. LOAD: capture SK, N, A, P into internal registers. Set x0 = IV = 0x80400c0600000000, x1 = K0, x2 = K1, x3 = N0, x4 = N1.
  2. INIT: p12, then x3 ^= K0 and x4 ^= K1.
  3. AD1: x0 ^= A, then p6.
  4. AD2 (padding block): x0 ^= 0x8000000000000000, then p6, then x4 ^= 1.
  5. PT: x0 ^= P; C_int = x0 after this XOR; then p6.
  6. PAD: x0 ^= 0x8000000000000000 (empty last block, no permutation).
  7. FINAL: x1 ^= K0, x2 ^= K1, then p12. T_int = {x3 ^ K0, x4 ^ K1}.
  8. DONE: C and T are written from C_int/T_int. Return to LOAD.
- The key and data XORs of each phase are folded into the first or last round cycle of that phase. They consume no extra cycles.
- Restart rule: in every cycle after LOAD, live SK/N/A/P are compared with the captured copies. On any mismatch the FSM returns to LOAD on the next edge; C and T are not updated.
- FSM states: LOAD, INIT, AD1, AD2, PT, FINAL. A 4-bit round counter runs within each state.

## Timing
- Reset values: C = 0, T = 0, FSM = LOAD, round counter = 0, state words = 0.
- A reset mid-run aborts the run. Outputs return to 0 immediately.
- Cycle budget:
  - 1 LOAD cycle.
  - 42 round cycles (12 + 6 + 6 + 6 + 12).
  - C/T load on the edge that completes the final round.
- Latency: C and T are valid 43 rising edges after the LOAD edge, i.e. within 44 cycles of the last input change.
- Outputs hold until the next completed run. Unchanged inputs recompute identical values, so outputs stay stable.
- Any input change during a run causes an abort and restart. No partially computed result is ever published.

## Structure
- Package ascon_pkg:
  - state typedef (5×64);
  - IV constant;
  - padding constant 0x8000000000000000;
  - rc function;
  - phase enum.
- Sub-module ascon_round: purely combinational; inputs are the 320-bit state and the 4-bit round index i; output is the next state. There is a single instance, reused for all phases.
- The top level holds the FSM, round counter, input capture/compare registers, phase XOR muxing, and output registers.

## Test plan
- Reset: assert RST for 10 ns at t = 1 ns -> C = 0 and T = 0 during reset and until the first run completes.
- Zero vector: SK = N = A = P = 0 -> after 43 edges, C/T match a software Ascon-128 reference model for 8-byte AD and 8-byte PT.
- KAT: SK = N = 000102…0F, A = P = 0001020304050607 -> C‖T equals official Ascon-128 KAT Count = 273 (8-byte AD, 8-byte PT).
- Back-to-back: 500 random vectors, each held 45 cycles -> C/T match the model at cycle 44 of every vector.
- Mid-run change: change P at round 20 -> C/T remain at the old values until 43 edges after the restart LOAD, then show the new result. No glitch value appears.
- Mid-run reset: assert RST at FINAL round 5 -> outputs are 0 immediately; the next run completes correctly.
